// File: rtl/dense_neuron_cell.sv
// rtl/dense_neuron_cell.sv - one dense-layer neuron of a systolic chain with result-chain merge
//
// Purpose:
//   Forwards the (index, value, enable) element stream to the next cell one
//   cycle late and accumulates signed value*weight[index] per input vector.
//   When index WEIGHT_AMOUNT-1 arrives, acc + BIAS is narrowed to DATA_WIDTH
//   and queued in a small result FIFO. The FIFO drains into the result chain
//   only on cycles where no upstream result is passing through.
//
// Optional feature macro:
//   DENSE_NEURON_SATURATE_EN - when defined, the narrowed result saturates to the
//   signed DATA_WIDTH range; otherwise it wraps (low DATA_WIDTH bits).
//
// Ports:
//   clk            in   1              clock, rising edge
//   rst            in   1              synchronous reset, active-high
//   input_index    in   DATA_WIDTH     element index
//   input_value    in   DATA_WIDTH     element value (signed)
//   input_enable   in   1              index/value valid this cycle
//   input_result   in   DATA_WIDTH+1   upstream result {valid, payload}
//   output_index   out  DATA_WIDTH     input_index delayed one cycle
//   output_value   out  DATA_WIDTH     input_value delayed one cycle
//   output_enable  out  1              input_enable delayed one cycle
//   output_result  out  DATA_WIDTH+1   merged result chain {valid, payload}
//   error_flag     out  1              sticky: out-of-range index or FIFO overflow

module dense_neuron_cell #(
    parameter int                                  DATA_WIDTH        = 32,
    parameter int                                  WEIGHT_AMOUNT     = 4,
    parameter int                                  ACC_WIDTH         = 2*DATA_WIDTH+8,
    parameter logic [WEIGHT_AMOUNT*DATA_WIDTH-1:0] WEIGHTS           = '0,
    parameter logic [DATA_WIDTH-1:0]               BIAS              = '0,
    parameter int                                  RESULT_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_index,
    input  logic [DATA_WIDTH-1:0] input_value,
    input  logic                  input_enable,
    input  logic [DATA_WIDTH:0]   input_result,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic                  output_enable,
    output logic [DATA_WIDTH:0]   output_result,
    output logic                  error_flag
);

    localparam int PTR_W = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESULT_FIFO_DEPTH + 1);
    localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESULT_FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RESULT_FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0] fifo_mem [RESULT_FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                  index_ok;
    logic                  index_first;
    logic                  index_last;
    logic                  accumulate;
    logic                  bad_index;
    logic                  complete;
    logic [DATA_WIDTH-1:0] weight_sel;
    logic [ACC_WIDTH-1:0]  value_ext;
    logic [ACC_WIDTH-1:0]  weight_ext;
    logic [ACC_WIDTH-1:0]  product;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [DATA_WIDTH-1:0] sum_narrow;

    assign index_ok    = (input_index < DATA_WIDTH'(WEIGHT_AMOUNT));
    assign index_first = (input_index == '0);
    assign index_last  = (input_index == DATA_WIDTH'(WEIGHT_AMOUNT - 1));
    assign accumulate  = input_enable && index_ok;
    assign bad_index   = input_enable && !index_ok;
    assign complete    = accumulate && index_last;

    // Weight lookup: a decoded mux over the constant weight vector, so an
    // out-of-range index simply selects zero (it never accumulates anyway).
    always_comb begin
        weight_sel = '0;
        for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
            if (input_index == DATA_WIDTH'(i)) begin
                weight_sel = WEIGHTS[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Both operands sign-extended to the accumulator width; the low
    // ACC_WIDTH bits of the product are then exact for signed operands.
    assign value_ext  = {{EXT_W{input_value[DATA_WIDTH-1]}}, input_value};
    assign weight_ext = {{EXT_W{weight_sel[DATA_WIDTH-1]}}, weight_sel};
    assign product    = value_ext * weight_ext;

    // Index 0 restarts the vector, dropping any partial sum.
    assign acc_next = index_first ? product : (acc + product);

`ifdef DENSE_NEURON_SATURATE_EN
    logic [ACC_WIDTH-1:0] bias_ext;
    logic [ACC_WIDTH-1:0] sum;

    assign bias_ext = {{EXT_W{BIAS[DATA_WIDTH-1]}}, BIAS};
    assign sum      = acc_next + bias_ext;

    // The sum fits in DATA_WIDTH exactly when every bit above the narrow
    // sign bit equals the wide sign bit; otherwise clamp toward that sign.
    always_comb begin
        sum_narrow = sum[DATA_WIDTH-1:0];
        if (sum[ACC_WIDTH-1:DATA_WIDTH-1] != {(EXT_W+1){sum[ACC_WIDTH-1]}}) begin
            sum_narrow = sum[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    // Wrapping result only depends on the low bits of the accumulator.
    assign sum_narrow = acc_next[DATA_WIDTH-1:0] + BIAS;
`endif

    // ------------------------------------------------------------------
    // Result FIFO control
    // ------------------------------------------------------------------
    logic upstream_valid;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic overflow;

    assign upstream_valid = input_result[DATA_WIDTH];
    assign fifo_empty     = (count == '0);
    assign fifo_full      = (count == CNT_FULL);
    // Upstream results own the chain; the queue only drains in gaps.
    assign pop            = !upstream_valid && !fifo_empty;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign push           = complete && (!fifo_full || pop);
    assign overflow       = complete && fifo_full && !pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            output_index  <= '0;
            output_value  <= '0;
            output_enable <= 1'b0;
            output_result <= '0;
            error_flag    <= 1'b0;
            acc           <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            output_index  <= input_index;
            output_value  <= input_value;
            output_enable <= input_enable;

            if (accumulate) begin
                acc <= acc_next;
            end

            if (upstream_valid) begin
                output_result <= input_result;
            end else if (pop) begin
                output_result <= {1'b1, fifo_mem[rd_ptr]};
            end else begin
                output_result <= '0;
            end

            if (push) begin
                fifo_mem[wr_ptr] <= sum_narrow;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (bad_index || overflow) begin
                error_flag <= 1'b1;
            end
        end
    end

endmodule
